// File: rtl/sc_core_rv32i_pkg.sv
// Shared constants, opcode/ALU-op encodings and the funct3 -> ALU-op decoder
// for the single-cycle RV32I core.
package sc_core_rv32i_pkg;

  localparam int unsigned I_MEM_MSB    = 32'd1023;
  localparam logic [31:0] D_MEM_OFFSET = 32'h0000_1000;
  localparam int unsigned D_MEM_SIZE   = 32'd1024;
  localparam logic [31:0] EBREAK       = 32'h0010_0073;

  typedef enum logic [6:0] {
    OPC_LUI    = 7'b0110111,
    OPC_AUIPC  = 7'b0010111,
    OPC_JAL    = 7'b1101111,
    OPC_JALR   = 7'b1100111,
    OPC_BRANCH = 7'b1100011,
    OPC_LOAD   = 7'b0000011,
    OPC_STORE  = 7'b0100011,
    OPC_OP_IMM = 7'b0010011,
    OPC_OP     = 7'b0110011,
    OPC_FENCE  = 7'b0001111,
    OPC_SYSTEM = 7'b1110011
  } opcode_e;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9,
    ALU_IN2  = 4'd10
  } alu_op_e;

  // Bit 30 selects SUB only for register-register ops; for shifts it selects SRA in both forms.
  function automatic alu_op_e alu_op_decode(input logic [2:0] funct3, input logic alt,
                                            input logic is_reg);
    alu_op_e op;
    case (funct3)
      3'b000:  op = (is_reg && alt) ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      3'b111:  op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/sc_core_rv32i_if.sv
// Instruction-fetch and data-memory bus between the core (master) and the memories (slave).
interface sc_core_rv32i_if;
  logic [31:0] Pc;
  logic [31:0] Instruction;
  logic [31:0] DMemAddress;
  logic [31:0] DMemData;
  logic [3:0]  DMemByteEn;
  logic        DMemWrEn;
  logic        DMemRdEn;
  logic [31:0] DMemRspData;

  modport master (
    output Pc, DMemAddress, DMemData, DMemByteEn, DMemWrEn, DMemRdEn,
    input  Instruction, DMemRspData
  );

  modport slave (
    input  Pc, DMemAddress, DMemData, DMemByteEn, DMemWrEn, DMemRdEn,
    output Instruction, DMemRspData
  );
endinterface

// File: rtl/sc_core_rv32i_alu.sv
// Purely combinational RV32I ALU; shifts use only the low five bits of operand b.
module sc_core_rv32i_alu
  import sc_core_rv32i_pkg::*;
(
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  alu_op_e     alu_op,
  output logic [31:0] result
);
  logic [4:0] shamt_s;

  assign shamt_s = op_b[4:0];

  always_comb begin
    result = 32'd0;
    case (alu_op)
      ALU_ADD:  result = op_a + op_b;
      ALU_SUB:  result = op_a - op_b;
      ALU_SLL:  result = op_a << shamt_s;
      ALU_SLT:  result = {31'd0, $signed(op_a) < $signed(op_b)};
      ALU_SLTU: result = {31'd0, op_a < op_b};
      ALU_XOR:  result = op_a ^ op_b;
      ALU_SRL:  result = op_a >> shamt_s;
      ALU_SRA:  result = 32'($signed(op_a) >>> shamt_s);
      ALU_OR:   result = op_a | op_b;
      ALU_AND:  result = op_a & op_b;
      ALU_IN2:  result = op_b;
      default:  result = 32'd0;
    endcase
  end
endmodule

// File: rtl/sc_core_rv32i.sv
// Single-cycle RV32I core: decode, immediates, register file, branch compare,
// load extension and next-Pc selection; every instruction retires in one clock.
module sc_core_rv32i
  import sc_core_rv32i_pkg::*;
(
  input logic             Clk,
  input logic             Rst,
  sc_core_rv32i_if.master bus
);
  logic [31:0] pc_q, pc_d, pc_plus4_s;
  logic [31:0] regs_q [32];
  logic [31:0] regs_d [32];

  logic [31:0] instr_s;
  logic [6:0]  opcode_s;
  logic [4:0]  rd_s, rs1_s, rs2_s;
  logic [2:0]  funct3_s;
  logic [31:0] imm_i_s, imm_s_s, imm_b_s, imm_u_s, imm_j_s;
  logic [31:0] rs1_val_s, rs2_val_s;
  logic [31:0] alu_a_s, alu_b_s, alu_res_s;
  alu_op_e     alu_op_s;
  logic        rd_we_s, is_load_s, is_store_s, is_branch_s, is_jal_s, is_jalr_s;
  logic        branch_taken_s;
  logic [31:0] load_val_s, rd_wdata_s;
  logic [3:0]  byte_en_s;

  assign instr_s    = bus.Instruction;
  assign opcode_s   = instr_s[6:0];
  assign rd_s       = instr_s[11:7];
  assign funct3_s   = instr_s[14:12];
  assign rs1_s      = instr_s[19:15];
  assign rs2_s      = instr_s[24:20];
  assign imm_i_s    = {{20{instr_s[31]}}, instr_s[31:20]};
  assign imm_s_s    = {{20{instr_s[31]}}, instr_s[31:25], instr_s[11:7]};
  assign imm_b_s    = {{19{instr_s[31]}}, instr_s[31], instr_s[7], instr_s[30:25], instr_s[11:8], 1'b0};
  assign imm_u_s    = {instr_s[31:12], 12'd0};
  assign imm_j_s    = {{11{instr_s[31]}}, instr_s[31], instr_s[19:12], instr_s[20], instr_s[30:21], 1'b0};
  // regs_q[0] is never written, so x0 reads as zero without a special case.
  assign rs1_val_s  = regs_q[rs1_s];
  assign rs2_val_s  = regs_q[rs2_s];
  assign pc_plus4_s = pc_q + 32'd4;

  always_comb begin
    alu_a_s     = rs1_val_s;
    alu_b_s     = rs2_val_s;
    alu_op_s    = ALU_ADD;
    rd_we_s     = 1'b0;
    is_load_s   = 1'b0;
    is_store_s  = 1'b0;
    is_branch_s = 1'b0;
    is_jal_s    = 1'b0;
    is_jalr_s   = 1'b0;
    case (opcode_s)
      OPC_LUI:    begin alu_b_s = imm_u_s; alu_op_s = ALU_IN2; rd_we_s = 1'b1; end
      OPC_AUIPC:  begin alu_a_s = pc_q; alu_b_s = imm_u_s; rd_we_s = 1'b1; end
      OPC_JAL:    begin is_jal_s = 1'b1; rd_we_s = 1'b1; end
      OPC_JALR:   begin alu_b_s = imm_i_s; is_jalr_s = 1'b1; rd_we_s = 1'b1; end
      OPC_BRANCH: is_branch_s = 1'b1;
      OPC_LOAD:   begin alu_b_s = imm_i_s; is_load_s = 1'b1; rd_we_s = 1'b1; end
      OPC_STORE:  begin alu_b_s = imm_s_s; is_store_s = 1'b1; end
      OPC_OP_IMM: begin
        alu_b_s  = imm_i_s;
        alu_op_s = alu_op_decode(funct3_s, instr_s[30], 1'b0);
        rd_we_s  = 1'b1;
      end
      OPC_OP:     begin
        alu_op_s = alu_op_decode(funct3_s, instr_s[30], 1'b1);
        rd_we_s  = 1'b1;
      end
      // FENCE, SYSTEM and undefined opcodes retire with no side effects.
      default:    rd_we_s = 1'b0;
    endcase
  end

  sc_core_rv32i_alu u_alu (
    .op_a   (alu_a_s),
    .op_b   (alu_b_s),
    .alu_op (alu_op_s),
    .result (alu_res_s)
  );

  always_comb begin
    branch_taken_s = 1'b0;
    case (funct3_s)
      3'b000:  branch_taken_s = (rs1_val_s == rs2_val_s);
      3'b001:  branch_taken_s = (rs1_val_s != rs2_val_s);
      3'b100:  branch_taken_s = ($signed(rs1_val_s) < $signed(rs2_val_s));
      3'b101:  branch_taken_s = ($signed(rs1_val_s) >= $signed(rs2_val_s));
      3'b110:  branch_taken_s = (rs1_val_s < rs2_val_s);
      3'b111:  branch_taken_s = (rs1_val_s >= rs2_val_s);
      default: branch_taken_s = 1'b0;
    endcase
  end

  always_comb begin
    load_val_s = bus.DMemRspData;
    case (funct3_s)
      3'b000:  load_val_s = {{24{bus.DMemRspData[7]}}, bus.DMemRspData[7:0]};
      3'b001:  load_val_s = {{16{bus.DMemRspData[15]}}, bus.DMemRspData[15:0]};
      3'b100:  load_val_s = {24'd0, bus.DMemRspData[7:0]};
      3'b101:  load_val_s = {16'd0, bus.DMemRspData[15:0]};
      default: load_val_s = bus.DMemRspData;
    endcase
  end

  always_comb begin
    byte_en_s = 4'b0000;
    if (is_store_s) begin
      case (funct3_s)
        3'b000:  byte_en_s = 4'b0001;
        3'b001:  byte_en_s = 4'b0011;
        3'b010:  byte_en_s = 4'b1111;
        default: byte_en_s = 4'b0000;
      endcase
    end else begin
      byte_en_s = 4'b0000;
    end
  end

  always_comb begin
    if (is_load_s) begin
      rd_wdata_s = load_val_s;
    end else if (is_jal_s || is_jalr_s) begin
      rd_wdata_s = pc_plus4_s;
    end else begin
      rd_wdata_s = alu_res_s;
    end
    regs_d = regs_q;
    if (rd_we_s && (rd_s != 5'd0)) begin
      regs_d[rd_s] = rd_wdata_s;
    end else begin
      regs_d[0] = 32'd0;
    end
  end

  always_comb begin
    if (is_branch_s && branch_taken_s) begin
      pc_d = pc_q + imm_b_s;
    end else if (is_jal_s) begin
      pc_d = pc_q + imm_j_s;
    end else if (is_jalr_s) begin
      pc_d = alu_res_s & 32'hFFFF_FFFE;
    end else begin
      pc_d = pc_plus4_s;
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      pc_q <= 32'd0;
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= 32'd0;
      end
    end else begin
      pc_q   <= pc_d;
      regs_q <= regs_d;
    end
  end

  // Strobes are gated by reset so a store in flight when reset asserts is dropped.
  assign bus.Pc          = pc_q;
  assign bus.DMemAddress = alu_res_s;
  assign bus.DMemData    = rs2_val_s;
  assign bus.DMemByteEn  = Rst ? byte_en_s : 4'b0000;
  assign bus.DMemWrEn    = Rst & is_store_s & (byte_en_s != 4'b0000);
  assign bus.DMemRdEn    = Rst & is_load_s;
endmodule

// File: tb/tb_sc_core_rv32i.sv
// Directed bench for sc_core_rv32i: instructions are driven one per cycle and
// register contents are observed as DMemAddress of an "addi x0,xN,0" probe.
module tb_sc_core_rv32i;
  import sc_core_rv32i_pkg::*;

  logic Clk;
  logic Rst;
  sc_core_rv32i_if bus ();

  sc_core_rv32i dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;
  logic [31:0] pc_exp;
  logic [31:0] pc_cur;
  logic [31:0] pj;

  // Data memory model: 256 bytes starting at D_MEM_OFFSET, combinational read.
  logic [7:0] dmem [256];
  logic [7:0] moff_s;
  assign moff_s = 8'(bus.DMemAddress - D_MEM_OFFSET);
  assign bus.DMemRspData = {dmem[moff_s + 8'd3], dmem[moff_s + 8'd2],
                            dmem[moff_s + 8'd1], dmem[moff_s]};

  always @(posedge Clk) begin
    if (bus.DMemWrEn) begin
      for (int k = 0; k < 4; k++) begin
        if (bus.DMemByteEn[k]) dmem[moff_s + 8'(k)] <= bus.DMemData[8*k +: 8];
      end
    end
  end

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd);
    return {imm, rd, 7'b0110111};
  endfunction

  function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction

  // Present one instruction mid-cycle and check it is fetched at the expected Pc.
  task automatic issue(input logic [31:0] ins);
    @(negedge Clk);
    bus.Instruction = ins;
    #1;
    check_eq("pc", bus.Pc, pc_exp);
    pc_cur = pc_exp;
    pc_exp = pc_exp + 32'd4;
  endtask

  task automatic probe(input logic [4:0] r, input logic [31:0] exp, input string tag);
    issue(enc_i(12'd0, r, 3'b000, 5'd0, OPC_OP_IMM));
    check_eq(tag, bus.DMemAddress, exp);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) dmem[i] <= 8'd0;
    Rst = 1'b0;
    pc_exp = 32'd0;
    pc_cur = 32'd0;
    pj = 32'd0;
    bus.Instruction = 32'h0000_0013;
    repeat (4) @(posedge Clk);
    #1;
    bus.Instruction = enc_s(12'd0, 5'd0, 5'd0, 3'b010);
    #1;
    check_eq("rst_pc", bus.Pc, 32'd0);
    check_eq("rst_wren", {31'd0, bus.DMemWrEn}, 32'd0);
    check_eq("rst_rden", {31'd0, bus.DMemRdEn}, 32'd0);
    check_eq("rst_byteen", {28'd0, bus.DMemByteEn}, 32'd0);
    @(posedge Clk);
    #1 Rst = 1'b1;
    bus.Instruction = 32'h0000_0013;

    repeat (4) issue(32'h0000_0013);

    issue(enc_i(12'hFFB, 5'd0, 3'b000, 5'd1, OPC_OP_IMM));
    issue(enc_i(12'h401, 5'd1, 3'b101, 5'd2, OPC_OP_IMM));
    issue(enc_r(7'd0, 5'd1, 5'd0, 3'b011, 5'd3));
    issue(enc_r(7'b0100000, 5'd1, 5'd0, 3'b000, 5'd4));
    check_eq("alu_wren", {31'd0, bus.DMemWrEn}, 32'd0);
    probe(5'd1, 32'hFFFF_FFFB, "addi_x1");
    probe(5'd2, 32'hFFFF_FFFD, "srai_x2");
    probe(5'd3, 32'h0000_0001, "sltu_x3");
    probe(5'd4, 32'h0000_0005, "sub_x4");

    issue(enc_i(12'd33, 5'd0, 3'b000, 5'd16, OPC_OP_IMM));
    issue(enc_i(12'd3, 5'd0, 3'b000, 5'd17, OPC_OP_IMM));
    issue(enc_r(7'd0, 5'd16, 5'd17, 3'b001, 5'd18));
    probe(5'd18, 32'h0000_0006, "sll_x18");

    issue(enc_u(20'h00001, 5'd5));
    issue(enc_i(12'h080, 5'd0, 3'b000, 5'd6, OPC_OP_IMM));
    issue(enc_s(12'd1, 5'd6, 5'd5, 3'b000));
    check_eq("sb_byteen", {28'd0, bus.DMemByteEn}, 32'h0000_0001);
    check_eq("sb_addr", bus.DMemAddress, 32'h0000_1001);
    check_eq("sb_wren", {31'd0, bus.DMemWrEn}, 32'd1);
    check_eq("sb_data", bus.DMemData, 32'h0000_0080);
    issue(enc_i(12'd1, 5'd5, 3'b000, 5'd7, OPC_LOAD));
    check_eq("lb_wren", {31'd0, bus.DMemWrEn}, 32'd0);
    check_eq("lb_rden", {31'd0, bus.DMemRdEn}, 32'd1);
    check_eq("lb_byteen", {28'd0, bus.DMemByteEn}, 32'd0);
    check_eq("lb_addr", bus.DMemAddress, 32'h0000_1001);
    issue(enc_i(12'd1, 5'd5, 3'b100, 5'd8, OPC_LOAD));
    probe(5'd7, 32'hFFFF_FF80, "lb_x7");
    probe(5'd8, 32'h0000_0080, "lbu_x8");

    issue(enc_u(20'h12345, 5'd9));
    issue(enc_i(12'h678, 5'd9, 3'b000, 5'd9, OPC_OP_IMM));
    issue(enc_s(12'd8, 5'd9, 5'd5, 3'b010));
    check_eq("sw_byteen", {28'd0, bus.DMemByteEn}, 32'h0000_000F);
    check_eq("sw_data", bus.DMemData, 32'h1234_5678);
    issue(enc_i(12'd8, 5'd5, 3'b001, 5'd10, OPC_LOAD));
    issue(enc_i(12'd8, 5'd5, 3'b101, 5'd11, OPC_LOAD));
    issue(enc_i(12'd8, 5'd5, 3'b010, 5'd12, OPC_LOAD));
    probe(5'd10, 32'h0000_5678, "lh_x10");
    probe(5'd11, 32'h0000_5678, "lhu_x11");
    probe(5'd12, 32'h1234_5678, "lw_x12");

    issue(enc_b(13'd8, 5'd0, 5'd0, 3'b000));
    pc_exp = pc_cur + 32'd8;
    issue(enc_i(12'd1, 5'd0, 3'b000, 5'd13, OPC_OP_IMM));
    issue(enc_i(12'hFFF, 5'd0, 3'b000, 5'd14, OPC_OP_IMM));
    issue(enc_b(13'd12, 5'd14, 5'd13, 3'b110));
    pc_exp = pc_cur + 32'd12;
    issue(enc_b(13'd12, 5'd14, 5'd13, 3'b100));
    issue(enc_b(13'd8, 5'd14, 5'd13, 3'b101));
    pc_exp = pc_cur + 32'd8;

    issue(enc_j(21'd16, 5'd1));
    pj = pc_cur;
    pc_exp = pj + 32'd16;
    probe(5'd1, pj + 32'd4, "jal_link");
    issue(enc_i(12'd1, 5'd1, 3'b000, 5'd0, OPC_JALR));
    pc_exp = pj + 32'd4;

    issue(enc_i(12'd7, 5'd0, 3'b000, 5'd0, OPC_OP_IMM));
    probe(5'd0, 32'd0, "x0_zero");
    issue(EBREAK);
    check_eq("ebreak_wren", {31'd0, bus.DMemWrEn}, 32'd0);
    check_eq("ebreak_rden", {31'd0, bus.DMemRdEn}, 32'd0);
    issue(32'h0000_07FF);
    probe(5'd15, 32'd0, "undef_x15");

    @(negedge Clk);
    bus.Instruction = enc_s(12'd16, 5'd9, 5'd5, 3'b010);
    #1 Rst = 1'b0;
    #1;
    check_eq("midrst_pc", bus.Pc, 32'd0);
    check_eq("midrst_wren", {31'd0, bus.DMemWrEn}, 32'd0);
    @(posedge Clk);
    #1;
    check_eq("midrst_mem", {dmem[19], dmem[18], dmem[17], dmem[16]}, 32'd0);
    Rst = 1'b1;
    pc_exp = 32'd0;
    probe(5'd9, 32'd0, "midrst_x9");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sc_core_rv32i.md
# sc_core_rv32i

Single-cycle RV32I integer core (DUT name `sc_core`): every instruction is fetched, decoded, executed and retired in one clock cycle. It drives a byte-addressed instruction-memory address and reads the instruction back combinationally. It drives a byte-addressed data-memory port with a combinational read response and a write that the memory commits on the next rising clock edge. It sits between the instruction memory and the data memory in the `sc_core` subsystem.

## Interface
Parameters (shared constants, from `sc_core_pkg`):
- I_MEM_MSB, package constant: top byte index of instruction memory; base address 0.
- D_MEM_OFFSET, package constant: first byte address of data memory.
- D_MEM_SIZE, package constant: data memory size in bytes.

Ports:
- Clk  in  1  core clock; all state updates on the rising edge.
- Rst  in  1  reset; one clock, asynchronous and active-low.
- Pc  out  32  byte address of the current instruction.
- Instruction  in  32  instruction word at Pc, combinational, little-endian.
- DMemAddress  out  32  byte address for loads and stores.
- DMemData  out  32  store data, unshifted: byte 0 is in [7:0].
- DMemByteEn  out  4  SB=0001, SH=0011, SW=1111; 0000 otherwise.
- DMemWrEn  out  1  store strobe; the memory commits on the next rising edge.
- DMemRdEn  out  1  high for load instructions.
- DMemRspData  in  32  combinational read of bytes DMemAddress..+3; byte at DMemAddress is in [7:0].

## Operation
- ISA: full RV32I base integer set.
  - LUI, AUIPC, JAL, JALR.
  - BEQ, BNE, BLT, BGE, BLTU, BGEU.
  - LB, LH, LW, LBU, LHU.
  - SB, SH, SW.
  - All OP-IMM and OP instructions.
  - FENCE, ECALL, EBREAK execute as NOPs (advance Pc by 4).
- Undefined opcode: NOP; no register or memory write.
- Register file: 32×32 bits.
  - x0 reads 0; writes to x0 are dropped.
  - All registers clear to 0 on reset.
- Next Pc:
  - Pc+4 by default.
  - Pc+immB when a branch is taken.
  - Pc+immJ for JAL.
  - (rs1+immI) & ~1 for JALR.
- Link value: rd gets Pc+4 for JAL and JALR.
- Address: DMemAddress = rs1 + sign-extended immediate (I-type for loads, S-type for stores). For all other instructions it is the ALU result, with both strobes low.
- Misaligned addresses are passed through unchanged; there is no trap.
- Loads:
  - LB/LBU take DMemRspData[7:0]; LH/LHU take [15:0]; LW takes [31:0].
  - Sign- or zero-extend per opcode.
- Stores: DMemData = rs2, unshifted.
- Shifts: use only the low 5 bits of the shift amount; SRA/SRAI are arithmetic.
- Comparisons: SLT/SLTI/BLT/BGE are signed; the U variants are unsigned.
- Overflow: all arithmetic is mod 2^32 with no overflow detection.

## Timing
- Latency: one instruction per cycle, CPI = 1. The register write and the Pc update occur on the same rising edge.
- Read-before-write: a source register reads the pre-edge value within the same cycle.
- While Rst is active (low):
  - Pc = 0 and all registers = 0.
  - DMemWrEn = 0, DMemRdEn = 0, DMemByteEn = 0.
- After reset release: the first fetch is at Pc = 0 on the first rising edge after Rst goes high.
- Store strobe: DMemWrEn is asserted only in the cycle the store instruction is at Pc.
- Load path: combinational from Pc → Instruction → address → DMemRspData → rd write-back; there are no stalls.
- Reset mid-operation: Pc returns to 0 immediately and registers clear; any in-cycle store is dropped.

## Structure
- `sc_core_pkg` holds:
  - memory constants: I_MEM_MSB, D_MEM_OFFSET, D_MEM_SIZE;
  - opcode enum: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP_IMM, OP, FENCE, SYSTEM;
  - ALU-op enum: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, IN2;
  - EBREAK constant 32'h00100073.
- Sub-module `sc_core_alu`: purely combinational ALU with two 32-bit operands plus an ALU-op, producing a 32-bit result.
- Top level contains: decode, immediate generation, register file, branch comparison, load extension and next-Pc logic.

## Test plan
- Reset and fetch: hold Rst low for 4 cycles → Pc = 0 with both strobes low. Release reset, run four NOPs → Pc reads 0, 4, 8, 12.
- ALU: addi x1,x0,-5; srai x2,x1,1; sltu x3,x0,x1; sub x4,x0,x1 → x1=0xFFFFFFFB, x2=0xFFFFFFFD, x3=1, x4=5.
- Store/load: x5 = D_MEM_OFFSET; x6 = 0x80; sb x6,1(x5) → ByteEn = 0001, address = D_MEM_OFFSET+1, WrEn for one cycle. Then lb x7,1(x5) → 0xFFFFFF80; lbu x8,1(x5) → 0x00000080.
- Word/half: sw 0x12345678 then lh and lhu at the same address → 0x00005678 for both. Then lw → 0x12345678.
- Control flow:
  - beq x0,x0,+8 → Pc skips one instruction.
  - bltu with 1 vs 0xFFFFFFFF → taken; blt with the same operands → not taken.
  - jal x1,+16 at Pc=0x20 → x1=0x24, Pc=0x30.
  - jalr x0,1(x1) → Pc=0x24.
- x0 and EBREAK: addi x0,x0,7 → x0 stays 0. EBREAK (0x00100073) presented at Pc → no register or memory write, Pc+4.
